// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared definitions for the memory bus arbiter and the
//               memory control units that talk to it: arbiter state
//               encoding and request-type constants.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Request type carried on bus_request_type
    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin picker with a two-level priority
//               class. High-priority requesters are considered first; if
//               none are requesting, all requesters are eligible. The
//               search starts just after the pointer and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] prio,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    localparam int c_sel_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_cand;
    logic [c_sel_w-1:0] w_pos;

    // Narrow to the priority class when it is populated, then take the first
    // candidate in rotation order starting at ptr+1.
    always_comb begin
        w_cand = (|(req & prio)) ? (req & prio) : req;
        pick   = '0;
        idx    = '0;
        found  = 1'b0;
        w_pos  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = c_sel_w'((int'(ptr) + k) % NUM_REQ);
            if (!found && w_cand[w_pos]) begin
                found       = 1'b1;
                pick[w_pos] = 1'b1;
                idx         = ID_W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Single-owner arbiter for the shared memory bus. Grants in
//               round-robin order with write-back requests ahead of reads,
//               tracks owner and bus direction, and revokes grants that are
//               not taken up within GRANT_TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int GRANT_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] bus_request,
    input  logic [NUM_REQ-1:0] bus_request_type,
    input  logic [NUM_REQ-1:0] bus_hold,
    input  logic [NUM_REQ-1:0] bus_direction_in,
    output logic [NUM_REQ-1:0] bus_get,
    output logic               owner_valid,
    output logic [ID_W-1:0]    owner_id,
    output logic               bus_direction,
    output logic               timeout_err
);

    localparam int c_tmr_w = $clog2(GRANT_TIMEOUT) + 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(GRANT_TIMEOUT - 1);

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [c_tmr_w-1:0]  r_timer;
    logic [NUM_REQ-1:0]  r_own_oh;
    logic [NUM_REQ-1:0]  r_bus_get;
    logic                r_owner_valid;
    logic [ID_W-1:0]     r_owner_id;
    logic                r_bus_direction;
    logic                r_timeout_err;

    logic [NUM_REQ-1:0]  w_prio;
    logic [NUM_REQ-1:0]  w_pick;
    logic [ID_W-1:0]     w_idx;
    logic                w_found;
    logic                w_own_req;
    logic                w_own_hold;
    logic                w_own_dir;

    // Write-back requests form the priority class.
    assign w_prio = bus_request_type ~^ {NUM_REQ{REQ_WB}};

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (bus_request),
        .prio  (w_prio),
        .ptr   (r_ptr),
        .pick  (w_pick),
        .idx   (w_idx),
        .found (w_found)
    );

    // Owner-qualified views of the per-unit inputs; non-owners are masked off.
    assign w_own_req  = |(bus_request      & r_own_oh);
    assign w_own_hold = |(bus_hold         & r_own_oh);
    assign w_own_dir  = |(bus_direction_in & r_own_oh);

    // Arbitration state machine with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            r_ptr           <= ID_W'(NUM_REQ - 1);
            r_timer         <= '0;
            r_own_oh        <= '0;
            r_bus_get       <= '0;
            r_owner_valid   <= 1'b0;
            r_owner_id      <= '0;
            r_bus_direction <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_bus_get     <= w_pick;
                        r_own_oh      <= w_pick;
                        r_owner_id    <= w_idx;
                        r_owner_valid <= 1'b1;
                        r_ptr         <= w_idx;
                        r_timer       <= '0;
                        r_state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_own_hold) begin
                        r_bus_get       <= '0;
                        r_bus_direction <= w_own_dir;
                        r_state         <= BUSY;
                    end else if (!w_own_req) begin
                        r_bus_get       <= '0;
                        r_owner_valid   <= 1'b0;
                        r_bus_direction <= 1'b0;
                        r_state         <= RELEASE;
                    end else if (r_timer == c_tmr_last) begin
                        r_bus_get       <= '0;
                        r_owner_valid   <= 1'b0;
                        r_bus_direction <= 1'b0;
                        r_timeout_err   <= 1'b1;
                        r_state         <= RELEASE;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                BUSY: begin
                    // Request is deliberately ignored here; only hold matters.
                    if (w_own_hold) begin
                        r_bus_direction <= w_own_dir;
                    end else begin
                        r_owner_valid   <= 1'b0;
                        r_bus_direction <= 1'b0;
                        r_state         <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Turnaround cycle: never grant here.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus_get       = r_bus_get;
    assign owner_valid   = r_owner_valid;
    assign owner_id      = r_owner_id;
    assign bus_direction = r_bus_direction;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter: directed vector
//               table, multi-cycle sequences (fairness, timeout, async
//               reset) and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, rtype, hold, dir;
    logic [N-1:0]   get;
    logic           valid;
    logic [IDW-1:0] id;
    logic           bdir;
    logic           terr;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NUM_REQ       (N),
        .ID_W          (IDW),
        .GRANT_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus_request      (req),
        .bus_request_type (rtype),
        .bus_hold         (hold),
        .bus_direction_in (dir),
        .bus_get          (get),
        .owner_valid      (valid),
        .owner_id         (id),
        .bus_direction    (bdir),
        .timeout_err      (terr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0]   req;
        logic [N-1:0]   typ;
        logic [N-1:0]   hold;
        logic [N-1:0]   dir;
        logic [N-1:0]   get;
        logic           valid;
        logic [IDW-1:0] id;
        logic           bdir;
        logic           err;
    } vec_t;

    vec_t tbl[23];

    // Reference model state (phase 0 idle, 1 granted, 2 held, 3 turnaround)
    int           m_phase, m_ptr, m_timer, m_owner;
    logic [N-1:0] e_get;
    logic         e_valid, e_dir, e_err;
    int           e_id;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(string tag, logic [N-1:0] eg, logic ev,
                                 logic [31:0] eid, logic ed, logic ee);
        check({tag, ".bus_get"},       32'(get),   32'(eg));
        check({tag, ".owner_valid"},   32'(valid), 32'(ev));
        check({tag, ".owner_id"},      32'(id),    eid);
        check({tag, ".bus_direction"}, 32'(bdir),  32'(ed));
        check({tag, ".timeout_err"},   32'(terr),  32'(ee));
    endtask

    function automatic vec_t mk(logic [N-1:0] rq, logic [N-1:0] ty, logic [N-1:0] hd,
                                logic [N-1:0] dr, logic [N-1:0] g, logic v,
                                logic [IDW-1:0] i, logic d, logic e);
        vec_t t;
        t.req = rq; t.typ = ty; t.hold = hd; t.dir = dr;
        t.get = g; t.valid = v; t.id = i; t.bdir = d; t.err = e;
        return t;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = N - 1; m_timer = 0; m_owner = 0;
        e_get = '0; e_valid = 0; e_id = 0; e_dir = 0; e_err = 0;
    endtask

    // One rising edge of the arbiter as described by its rules.
    task automatic model_edge(logic [N-1:0] rq, logic [N-1:0] ty,
                              logic [N-1:0] hd, logic [N-1:0] dr);
        logic [N-1:0] cand;
        int u;
        e_err = 0;
        case (m_phase)
            0: begin
                cand = rq & ty;
                if (cand == '0) cand = rq;
                for (int d = 1; d <= N; d++) begin
                    u = (m_ptr + d) % N;
                    if (m_phase == 0 && cand[u]) begin
                        m_phase = 1; m_owner = u; m_ptr = u; m_timer = 0;
                        e_get = '0; e_get[u] = 1'b1;
                        e_valid = 1; e_id = u; e_dir = 0;
                    end
                end
            end
            1: begin
                if (hd[m_owner]) begin
                    m_phase = 2; e_get = '0; e_dir = dr[m_owner];
                end else if (!rq[m_owner]) begin
                    m_phase = 3; e_get = '0; e_valid = 0; e_dir = 0;
                end else if (m_timer == TO - 1) begin
                    m_phase = 3; e_get = '0; e_valid = 0; e_dir = 0; e_err = 1;
                end else begin
                    m_timer++;
                end
            end
            2: begin
                if (hd[m_owner]) e_dir = dr[m_owner];
                else begin
                    m_phase = 3; e_valid = 0; e_dir = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; rtype = '0; hold = '0; dir = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", '0, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_index(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int idx;
        int cnt;
        bit hold_en;
        logic [N-1:0] flip;
        int exp_order[5];

        // ---------------- directed vector table ----------------
        //           req      type     hold     dir      get     v  id d  e
        tbl[0]  = mk(4'b1001, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 3, 0, 0);
        tbl[1]  = mk(4'b1001, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1, 3, 0, 0);
        tbl[2]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3, 0, 0);
        tbl[3]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3, 0, 0);
        tbl[4]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0);
        tbl[5]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0, 0, 0);
        tbl[6]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
        tbl[7]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0);
        tbl[8]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1, 2, 0, 0);
        tbl[9]  = mk(4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1, 2, 1, 0);
        tbl[10] = mk(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1, 2, 0, 0);
        tbl[11] = mk(4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1, 2, 1, 0);
        tbl[12] = mk(4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1, 2, 1, 0);
        tbl[13] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0, 0);
        tbl[14] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2, 0, 0);
        tbl[15] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 0);
        tbl[16] = mk(4'b0001, 4'b0000, 4'b0101, 4'b0100, 4'b0000, 1, 0, 0, 0);
        tbl[17] = mk(4'b0001, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 1, 0, 1, 0);
        tbl[18] = mk(4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 0);
        tbl[19] = mk(4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 0, 0, 0, 0);
        tbl[20] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1, 1, 0, 0);
        tbl[21] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0);
        tbl[22] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 0, 0);

        do_reset();
        for (int i = 0; i < 23; i++) begin
            req = tbl[i].req; rtype = tbl[i].typ; hold = tbl[i].hold; dir = tbl[i].dir;
            step();
            check_outputs($sformatf("vec%0d", i), tbl[i].get, tbl[i].valid,
                          32'(tbl[i].id), tbl[i].bdir, tbl[i].err);
        end

        // ---------------- round-robin fairness ----------------
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111; rtype = '0; hold = '0; dir = '0;
        for (int g = 0; g < 5; g++) begin
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (get == '0 && cnt < 10);
            check($sformatf("rr_grant%0d_onehot", g), 32'($onehot(get)), 32'd1);
            idx = oh_index(get);
            check($sformatf("rr_grant%0d_unit", g), 32'(idx), 32'(exp_order[g]));
            hold = get;
            step();
            step();
            hold = '0;
        end

        // ---------------- grant timeout ----------------
        do_reset();
        req = 4'b0010;
        step();
        check("to_first_grant", 32'(get), 32'b0010);
        cnt = (get == 4'b0010) ? 1 : 0;
        for (int c = 0; c < 20 && get[1]; c++) begin
            step();
            if (get[1]) cnt++;
        end
        check("to_grant_cycles", 32'(cnt), 32'(TO));
        check("to_err_pulse", 32'(terr), 32'd1);
        check("to_valid_dropped", 32'(valid), 32'd0);
        req = '0;
        step();
        check("to_err_single", 32'(terr), 32'd0);
        step();
        check("to_idle_get", 32'(get), 32'd0);
        check("to_idle_valid", 32'(valid), 32'd0);

        // ---------------- async reset in BUSY ----------------
        req = 4'b0001;
        step();
        check("ar_grant", 32'(get), 32'b0001);
        hold = 4'b0001; dir = 4'b0001;
        step();
        step();
        check("ar_busy_dir", 32'(bdir), 32'd1);
        check("ar_busy_valid", 32'(valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_outputs("ar_async", '0, 1'b0, 0, 1'b0, 1'b0);
        req = '0; hold = '0; dir = '0;
        step();
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // ---------------- randomized run against the model ----------------
        req = '0; rtype = '0; hold = '0; dir = '0;
        for (int c = 0; c < 400; c++) begin
            hold_en = ((c / 40) % 3) != 2;
            flip = '0;
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 9) < 2);
            req   = req ^ flip;
            rtype = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
            for (int b = 0; b < N; b++) hold[b] = hold_en && ($urandom_range(0, 9) < 7);
            dir   = N'($urandom_range(0, 15));
            @(posedge clk);
            model_edge(req, rtype, hold, dir);
            #1;
            check_outputs($sformatf("rand%0d", c), e_get, e_valid, 32'(e_id), e_dir, e_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
